// File: rtl/p1v_led_pkg.sv
// rtl/p1v_led_pkg.sv - shared constants and helpers for the cog LED driver
//
// Purpose: default geometry of the LED driver and the saturating counter
// helper used by every channel accumulator.
// Contents:
//   DEF_NUMLEDS    default number of LED channels (one per cog)
//   DEF_PRESCALE   default clock_160 cycles per sample tick (1 us at 160 MHz)
//   DEF_DUTY_BITS  default duty resolution; window = 2**DUTY_BITS ticks
//   DEF_MIN_LEVEL  default brightness floor for any channel that was active
//   sat_add        add one bit to a count, holding at max_val
package p1v_led_pkg;

  localparam int DEF_NUMLEDS   = 8;
  localparam int DEF_PRESCALE  = 160;
  localparam int DEF_DUTY_BITS = 8;
  localparam int DEF_MIN_LEVEL = 16;

  // Counts never exceed max_val, so holding at max_val is enough to keep a
  // fully active window from wrapping back to a dim level.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic        b,
                                          input logic [31:0] max_val);
    return (b && (a < max_val)) ? a + 32'd1 : a;
  endfunction

endpackage

// File: rtl/cog_led_chan.sv
// rtl/cog_led_chan.sv - one LED channel: activity accumulator, level, PWM compare
//
// Purpose: counts how many sample ticks in the current window saw the cog
// running, latches that count (stretched to a visible floor) as the channel
// level at the end of the window, and compares it with the shared PWM counter.
// Ports:
//   clock_160  in   system clock
//   inp_resn   in   asynchronous active-low reset
//   sample     in   registered cog activity bit
//   tick       in   sample tick from the shared prescaler
//   end_win    in   last tick of the window (tick is also high)
//   pwm_cnt    in   shared free-running PWM counter
//   level      out  latched displayed level
//   pwm_on     out  combinational PWM drive for this channel
module cog_led_chan
  import p1v_led_pkg::*;
#(
  parameter int DUTY_BITS = DEF_DUTY_BITS,
  parameter int MIN_LEVEL = DEF_MIN_LEVEL
) (
  input  logic                 clock_160,
  input  logic                 inp_resn,
  input  logic                 sample,
  input  logic                 tick,
  input  logic                 end_win,
  input  logic [DUTY_BITS-1:0] pwm_cnt,
  output logic [DUTY_BITS-1:0] level,
  output logic                 pwm_on
);

  localparam logic [31:0]          ACC_MAX = 32'((1 << DUTY_BITS) - 1);
  localparam logic [DUTY_BITS-1:0] MIN_L   = DUTY_BITS'(MIN_LEVEL);

  logic [DUTY_BITS-1:0] acc;
  logic [DUTY_BITS-1:0] raw;
  logic [DUTY_BITS-1:0] stretched;

  // raw already includes the current sample, so on the end-of-window tick the
  // final sample lands in the level rather than in the cleared accumulator.
  always_comb begin
    raw       = DUTY_BITS'(sat_add(32'(acc), sample, ACC_MAX));
    stretched = ((raw != '0) && (raw < MIN_L)) ? MIN_L : raw;
  end

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      acc   <= '0;
      level <= '0;
    end else if (end_win) begin
      acc   <= '0;
      level <= stretched;
    end else if (tick) begin
      acc   <= raw;
    end
  end

  // The all-ones case keeps a full-level LED lit through the one counter
  // value where the plain compare would drop it.
  always_comb begin
    pwm_on = (level == '1) || (pwm_cnt < level);
  end

endmodule

// File: rtl/cog_led_driver.sv
// rtl/cog_led_driver.sv - per-cog activity to LED brightness driver
//
// Purpose: sits between the core's per-cog LED vector and the board pins.
// Each channel's duty cycle over a fixed window of sample ticks is shown as
// PWM brightness; raw mode passes the registered inputs straight through.
// Ports:
//   clock_160      in   system clock, single domain
//   inp_resn       in   asynchronous active-low reset
//   led_in         in   cog activity, one bit per cog, clock_160 domain
//   raw_mode       in   1 = led_out follows registered led_in
//   led_out        out  registered board LED drive
//   level_out      out  latched level per channel, channel i at
//                       [i*DUTY_BITS +: DUTY_BITS]
//   window_strobe  out  one-cycle pulse when level_out takes new values
module cog_led_driver
  import p1v_led_pkg::*;
#(
  parameter int NUMLEDS   = DEF_NUMLEDS,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int DUTY_BITS = DEF_DUTY_BITS,
  parameter int MIN_LEVEL = DEF_MIN_LEVEL
) (
  input  logic                           clock_160,
  input  logic                           inp_resn,
  input  logic [NUMLEDS-1:0]             led_in,
  input  logic                           raw_mode,
  output logic [NUMLEDS-1:0]             led_out,
  output logic [NUMLEDS*DUTY_BITS-1:0]   level_out,
  output logic                           window_strobe
);

  // With PRESCALE == 1 the prescaler is a single bit pinned at zero, which
  // makes the terminal-count compare true on every cycle.
  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [DUTY_BITS-1:0] DUTY_ONE = DUTY_BITS'(1);

  logic [PRE_W-1:0]     pre_cnt;
  logic [DUTY_BITS-1:0] win_cnt;
  logic [DUTY_BITS-1:0] pwm_cnt;
  logic [NUMLEDS-1:0]   led_in_q;
  logic [NUMLEDS-1:0]   pwm_on;
  logic                 tick;
  logic                 end_win;

  always_comb begin
    tick    = (pre_cnt == PRE_LAST);
    end_win = tick && (win_cnt == '1);
  end

  // The source already lives in the clock_160 domain, so a single register
  // is enough to give every channel the same sampled view of the cogs.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      led_in_q <= '0;
    end else begin
      led_in_q <= led_in;
    end
  end

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      win_cnt <= '0;
    end else if (tick) begin
      win_cnt <= win_cnt + DUTY_ONE;
    end
  end

  // Free-running: a level change is picked up at the next compare rather
  // than being held back to a PWM period boundary.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_ONE;
    end
  end

  // Levels load on the end_win edge, so delaying end_win by one cycle lines
  // the strobe up with the first cycle the new levels are visible.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      window_strobe <= 1'b0;
    end else begin
      window_strobe <= end_win;
    end
  end

  for (genvar i = 0; i < NUMLEDS; i++) begin : g_chan
    cog_led_chan #(
      .DUTY_BITS (DUTY_BITS),
      .MIN_LEVEL (MIN_LEVEL)
    ) u_chan (
      .clock_160 (clock_160),
      .inp_resn  (inp_resn),
      .sample    (led_in_q[i]),
      .tick      (tick),
      .end_win   (end_win),
      .pwm_cnt   (pwm_cnt),
      .level     (level_out[i*DUTY_BITS +: DUTY_BITS]),
      .pwm_on    (pwm_on[i])
    );
  end

  // Accumulation keeps running underneath raw mode; only the pin source
  // changes.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      led_out <= '0;
    end else begin
      led_out <= raw_mode ? led_in_q : pwm_on;
    end
  end

endmodule

// File: tb/tb_cog_led_driver.sv
// tb/tb_cog_led_driver.sv - self-checking bench for cog_led_driver
//
// Three instances share clock and reset: PRESCALE 3, PRESCALE 1 and the
// default 160. Each cycle's outputs are predicted from window sums of the
// sampled inputs; a table of hand-computed spot values covers the corner cases.
module tb_cog_led_driver;

  localparam int ND     = 3;
  localparam int N1     = 600;
  localparam int N2     = 41300;
  localparam int NWIN   = 170;
  localparam int NSPOT  = 22;
  localparam int K_STB  = 0;
  localparam int K_LVL  = 1;
  localparam int K_LED  = 2;
  localparam int K_BYTE = 3;

  typedef struct {
    int         dut;
    int         cyc;
    int         kind;
    int         ch;
    logic [7:0] exp;
  } spot_t;

  logic        clk = 1'b0;
  logic        resn;
  logic [7:0]  li [ND];
  logic        rm [ND];
  logic [7:0]  lo [ND];
  logic [63:0] lv [ND];
  logic        st [ND];

  logic [7:0]  s_in    [ND][N2];
  logic        s_raw   [ND][N2];
  logic [7:0]  win_lvl [ND][NWIN][8];
  spot_t       spots   [NSPOT];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cog_led_driver #(.NUMLEDS(8), .PRESCALE(3), .DUTY_BITS(8), .MIN_LEVEL(16)) dut_a (
    .clock_160(clk), .inp_resn(resn), .led_in(li[0]), .raw_mode(rm[0]),
    .led_out(lo[0]), .level_out(lv[0]), .window_strobe(st[0]));

  cog_led_driver #(.NUMLEDS(8), .PRESCALE(1), .DUTY_BITS(8), .MIN_LEVEL(16)) dut_b (
    .clock_160(clk), .inp_resn(resn), .led_in(li[1]), .raw_mode(rm[1]),
    .led_out(lo[1]), .level_out(lv[1]), .window_strobe(st[1]));

  cog_led_driver #(.NUMLEDS(8), .PRESCALE(160), .DUTY_BITS(8), .MIN_LEVEL(16)) dut_c (
    .clock_160(clk), .inp_resn(resn), .led_in(li[2]), .raw_mode(rm[2]),
    .led_out(lo[2]), .level_out(lv[2]), .window_strobe(st[2]));

  function automatic int pres(int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 160;
  endfunction

  function automatic int wlen(int d);
    return 256 * pres(d);
  endfunction

  // Value of the registered input during cycle c (cycle 0 follows reset).
  function automatic logic [7:0] q_at(int d, int c);
    return (c >= 1) ? s_in[d][c-1] : 8'h00;
  endfunction

  // Level of each completed window: count of ticks that saw the cog active,
  // capped at 255, lifted to 16 when it is nonzero but below 16.
  task automatic compute_levels(int d, int n);
    int p;
    int wl;
    int cnt;
    logic [7:0] q;
    p  = pres(d);
    wl = wlen(d);
    for (int w = 0; w < NWIN; w++) begin
      for (int ch = 0; ch < 8; ch++) begin
        cnt = 0;
        if ((w + 1) * wl <= n) begin
          for (int t = 0; t < 256; t++) begin
            q = q_at(d, w * wl + t * p + p - 1);
            cnt += int'(q[ch]);
          end
        end
        if (cnt > 255) cnt = 255;
        if (cnt != 0 && cnt < 16) cnt = 16;
        win_lvl[d][w][ch] = 8'(cnt);
      end
    end
  endtask

  function automatic logic [7:0] lvl_at(int d, int c, int ch);
    int n;
    n = c / wlen(d);
    return (n == 0) ? 8'h00 : win_lvl[d][n-1][ch];
  endfunction

  task automatic check_cycle(int d, int c);
    logic [7:0]  e_led;
    logic [63:0] e_lvl;
    logic        e_stb;
    logic [7:0]  q;
    logic [7:0]  l;
    e_stb = (c > 0) && (c % wlen(d) == 0);
    e_lvl = '0;
    e_led = '0;
    for (int ch = 0; ch < 8; ch++) e_lvl[ch*8 +: 8] = lvl_at(d, c, ch);
    if (c > 0) begin
      q = q_at(d, c - 1);
      for (int ch = 0; ch < 8; ch++) begin
        l = lvl_at(d, c - 1, ch);
        e_led[ch] = s_raw[d][c-1] ? q[ch] : ((l == 8'hFF) || (((c - 1) % 256) < int'(l)));
      end
    end
    n_vec++;
    if ({lo[d], lv[d], st[d]} !== {e_led, e_lvl, e_stb}) begin
      n_bad++;
      $display("FAIL cycle dut=%0d cyc=%0d led_out=%h want %h level_out=%h want %h strobe=%b want %b",
               d, c, lo[d], e_led, lv[d], e_lvl, st[d], e_stb);
    end
  endtask

  task automatic check_spots(int c);
    logic [7:0] act;
    int d;
    int ch;
    for (int i = 0; i < NSPOT; i++) begin
      if (spots[i].cyc == c) begin
        d  = spots[i].dut;
        ch = spots[i].ch;
        case (spots[i].kind)
          K_STB:   act = {7'b0, st[d]};
          K_LVL:   act = lv[d][ch*8 +: 8];
          K_LED:   act = {7'b0, lo[d][ch]};
          default: act = lo[d];
        endcase
        n_vec++;
        if (act !== spots[i].exp) begin
          n_bad++;
          $display("FAIL spot%0d dut=%0d cyc=%0d kind=%0d ch=%0d got %h want %h",
                   i, d, c, spots[i].kind, ch, act, spots[i].exp);
        end
      end
    end
  endtask

  task automatic gen_random(int n);
    int   mode [ND][8];
    logic rawv [ND];
    logic b;
    for (int c = 0; c < n; c++) begin
      for (int d = 0; d < ND; d++) begin
        if (c % 256 == 0)
          for (int ch = 0; ch < 8; ch++) mode[d][ch] = $urandom_range(0, 4);
        if (c % 64 == 0) rawv[d] = ($urandom_range(0, 3) == 0);
        for (int ch = 0; ch < 8; ch++) begin
          case (mode[d][ch])
            0:       b = 1'b0;
            1:       b = ($urandom_range(0, 299) == 0);
            2:       b = ($urandom_range(0, 9) == 0);
            3:       b = 1'($urandom_range(0, 1));
            default: b = 1'b1;
          endcase
          s_in[d][c][ch] = b;
        end
        s_raw[d][c] = rawv[d];
      end
    end
  endtask

  task automatic drive(int c);
    for (int d = 0; d < ND; d++) begin
      li[d] = s_in[d][c];
      rm[d] = s_raw[d][c];
    end
  endtask

  task automatic run_segment(int n, bit spots_on);
    for (int d = 0; d < ND; d++) compute_levels(d, n);
    @(negedge clk);
    drive(0);
    resn = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check_cycle(d, 0);
    for (int c = 1; c < n; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) check_cycle(d, c);
      if (spots_on) check_spots(c);
      drive(c);
    end
  endtask

  initial begin
    spots = '{
      '{2, 40959, K_STB, 0, 8'h00}, '{2, 40959, K_LVL, 2, 8'h00},
      '{2, 40960, K_STB, 0, 8'h01}, '{2, 40960, K_LVL, 2, 8'd64},
      '{2, 40960, K_LVL, 5, 8'd16}, '{2, 40960, K_LVL, 6, 8'd0},
      '{2, 40960, K_LVL, 7, 8'd255}, '{2, 40961, K_STB, 0, 8'h00},
      '{2, 40961, K_LED, 6, 8'h00}, '{2, 40976, K_LED, 5, 8'h01},
      '{2, 40977, K_LED, 5, 8'h00}, '{2, 41024, K_LED, 2, 8'h01},
      '{2, 41025, K_LED, 2, 8'h00}, '{2, 41215, K_LED, 7, 8'h01},
      '{2, 41216, K_LED, 7, 8'h01}, '{2, 41217, K_LED, 2, 8'h01},
      '{1, 256,   K_STB, 0, 8'h01}, '{1, 256,   K_LVL, 0, 8'd128},
      '{0, 1002,  K_BYTE, 0, 8'hA5}, '{0, 1003, K_BYTE, 0, 8'h5A},
      '{2, 40960, K_LED, 7, 8'h00}, '{2, 40961, K_LED, 7, 8'h01}
    };

    resn = 1'b0;
    for (int d = 0; d < ND; d++) begin
      li[d] = '0;
      rm[d] = 1'b0;
    end
    repeat (2) @(posedge clk);

    gen_random(N1);
    run_segment(N1, 1'b0);

    // Reset mid-cycle, away from any clock edge: outputs must clear at once.
    #2;
    resn = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_vec++;
      if ({lo[d], lv[d], st[d]} !== 73'd0) begin
        n_bad++;
        $display("FAIL async_reset dut=%0d led_out=%h level_out=%h strobe=%b want all zero",
                 d, lo[d], lv[d], st[d]);
      end
    end
    @(posedge clk);

    gen_random(N2);
    for (int c = 0; c < N2; c++) begin
      s_raw[2][c]    = (c >= 20000 && c < 20200);
      s_in[2][c][2]  = (c < 10240);
      s_in[2][c][5]  = (c == 1758);
      s_in[2][c][6]  = (c == 1838);
      s_in[2][c][7]  = 1'b1;
      if (c < 256) s_in[1][c][0] = (c % 2 == 0);
      if (c >= 995 && c <= 1010) s_raw[0][c] = 1'b1;
    end
    s_in[0][1000] = 8'hA5;
    s_in[0][1001] = 8'h5A;
    run_segment(N2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
